// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO over one inferred RAM; standard (1-cycle read latency) or FWFT output.
// Writes stall on full, reads on empty; rejected requests drop and pulse overflow/underflow next cycle.
module fifo_sync_param #(
   parameter int WIDTH         = 36,
   parameter int DEPTH_LOG2    = 9,
   parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 4,
   parameter int AEMPTY_THRESH = 4,
   parameter bit FWFT          = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   output logic [WIDTH-1:0]      rd_data,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH_C  = PW'(1 << DEPTH_LOG2);
   localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

   logic [WIDTH-1:0] mem [1 << DEPTH_LOG2];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    ram_cnt;
   logic             wr_acc;
   logic             rd_acc;
   logic             ram_rd;

   // Words physically held in RAM; in FWFT mode this excludes the output register.
   assign ram_cnt      = wr_ptr - rd_ptr;

   assign full         = (count == DEPTH_C);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);
   assign wr_acc       = wr_en && !full;
   assign rd_acc       = rd_en && !empty;

   if (FWFT) begin : g_fwft
      logic out_valid;

      assign empty  = !out_valid;
      // Refill the output register whenever it is free or being popped this cycle.
      assign ram_rd = (ram_cnt != '0) && (!out_valid || rd_acc);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid <= 1'b0;
         end else if (ram_rd) begin
            out_valid <= 1'b1;
         end else if (rd_acc) begin
            out_valid <= 1'b0;
         end
      end
   end else begin : g_std
      assign empty  = (count == '0);
      assign ram_rd = rd_acc && (ram_cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (ram_rd) begin
         rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ram_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

endmodule
